// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the memory-port arbiter, its two requesters (IF and DM)
// and the single-ported instruction/data memory.
//   slave  : arbiter view (takes requests and memory read data, drives done/memory strobe)
//   master : environment view (requesters plus memory)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              grant_id;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_done, if_rdata, dm_done, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, busy, grant_id
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_done, if_rdata, dm_done, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy, grant_id
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch (IF) and the data
// stage (DM). Each access runs IDLE -> ISSUE -> WAIT -> DONE -> IDLE; the memory
// answers a fixed MEM_LAT cycles after its one-cycle mem_req strobe.
// Arbitration: DM wins ties, except that after STARVE_MAX consecutive DM grants
// made while IF was waiting, IF is served.
// Optional build macro ARB_ROUND_ROBIN_EN: ties alternate between requesters
// (tie-breaker starts as "IF last") and the starvation counter is removed.
// All outputs are registered and clear asynchronously on rst_n low.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam int                WAIT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_LAT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic                grant_s;
    logic                dm_win_s;
    logic [WAIT_W-1:0]   wait_cnt_r;

    logic                owner_r;
    logic                mem_req_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic                busy_r;
    logic                if_done_r;
    logic                dm_done_r;
    logic [DATA_W-1:0]   if_rdata_r;
    logic [DATA_W-1:0]   dm_rdata_r;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_dm_r;

    // Winner selection: alternate on ties, otherwise the only requester wins
    always_comb begin
        dm_win_s = 1'b0;
        if (bus.dm_req && bus.if_req) begin
            dm_win_s = ~last_dm_r;
        end else if (bus.dm_req) begin
            dm_win_s = 1'b1;
        end else begin
            dm_win_s = 1'b0;
        end
    end

    // Tie-breaker remembers who was granted last (reset value means "IF last")
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dm_r <= 1'b0;
        end else if (grant_s) begin
            last_dm_r <= dm_win_s;
        end
    end
`else
    localparam int                  STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

    logic [STARVE_W-1:0] starve_cnt_r;

    // Winner selection: DM priority unless IF has been passed over STARVE_MAX times
    always_comb begin
        dm_win_s = 1'b0;
        if (bus.dm_req && !(bus.if_req && (starve_cnt_r == STARVE_LIM))) begin
            dm_win_s = 1'b1;
        end else begin
            dm_win_s = 1'b0;
        end
    end

    // Starvation counter: counts DM grants that left IF waiting, cleared by an IF grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else if (grant_s) begin
            if (!dm_win_s) begin
                starve_cnt_r <= {STARVE_W{1'b0}};
            end else if (bus.if_req && (starve_cnt_r != STARVE_LIM)) begin
                starve_cnt_r <= starve_cnt_r + STARVE_ONE;
            end
        end
    end
`endif

    // Next-state logic; a grant is taken only from IDLE with a pending request
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    grant_s      = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_next_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_ZERO) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register plus the status/strobe outputs derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            mem_req_r <= 1'b0;
            if_done_r <= 1'b0;
            dm_done_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            busy_r    <= (state_next_s != ST_IDLE);
            mem_req_r <= (state_next_s == ST_ISSUE);
            if_done_r <= (state_next_s == ST_DONE) && !owner_r;
            dm_done_r <= (state_next_s == ST_DONE) && owner_r;
        end
    end

    // Latch the winner's access at grant; held on the memory bus until the next grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r     <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else if (grant_s) begin
            owner_r     <= dm_win_s;
            mem_we_r    <= dm_win_s & bus.dm_we;
            mem_addr_r  <= dm_win_s ? bus.dm_addr : bus.if_addr;
            mem_wdata_r <= dm_win_s ? bus.dm_wdata : {DATA_W{1'b0}};
        end
    end

    // Read-latency counter: loaded while issuing, counts down in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= WAIT_ZERO;
        end else if (state_r == ST_ISSUE) begin
            wait_cnt_r <= WAIT_LOAD;
        end else if ((state_r == ST_WAIT) && (wait_cnt_r != WAIT_ZERO)) begin
            wait_cnt_r <= wait_cnt_r - WAIT_ONE;
        end
    end

    // Capture read data on the last WAIT cycle into the owner's rdata (stores return 0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_r <= {DATA_W{1'b0}};
            dm_rdata_r <= {DATA_W{1'b0}};
        end else if ((state_r == ST_WAIT) && (wait_cnt_r == WAIT_ZERO)) begin
            if (owner_r) begin
                dm_rdata_r <= mem_we_r ? {DATA_W{1'b0}} : bus.mem_rdata;
            end else begin
                if_rdata_r <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.busy      = busy_r;
    assign bus.grant_id  = owner_r;
    assign bus.if_done   = if_done_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.dm_done   = dm_done_r;
    assign bus.dm_rdata  = dm_rdata_r;

endmodule
